pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the ID stage and consumes the decoded register read/write information: read enables and addresses, write enable and address, and a load flag. It keeps a two-entry scoreboard of in-flight destination registers (EX, MEM), drives the operand forwarding selects, inserts load-use bubbles and flushes on taken branches. It also freezes the pipe while data memory is busy, with a timeout watchdog and a stall-cycle performance counter.

## Interface
- `REG_ADDR_W`, 5: register address width
- `MEM_TIMEOUT`, 255: consecutive `mem_busy` cycles before `mem_timeout` sets; counter is 8 bits
- `clk` in 1: core clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `id_valid` in 1: ID holds a real instruction
- `id_read_en_1`, `id_read_en_2` in 1: source operand enables from ID decode
- `id_read_addr_1`, `id_read_addr_2` in `REG_ADDR_W`: source register addresses
- `id_write_en` in 1: ID instruction writes the register file
- `id_write_addr` in `REG_ADDR_W`: destination register
- `id_is_load` in 1: ID instruction is LB/LBU/LW
- `branch_taken` in 1: branch/jump resolved taken in ID
- `mem_busy` in 1: data memory not ready; MEM stage cannot complete
- `stall_if` out 1: hold PC and IF/ID
- `bubble_ex` out 1: load NOP into ID/EX
- `stall_all` out 1: freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB
- `flush_if` out 1: replace IF/ID with NOP
- `fwd_sel_1`, `fwd_sel_2` out 2: operand source; 0 = regfile, 1 = EX result, 2 = MEM result
- `mem_timeout` out 1: sticky watchdog error
- `stall_cnt` out 32: count of cycles with `stall_if` = 1

## Operation
- **Scoreboard tags.** Two tags, `ex_tag` and `mem_tag`. Each tag is {valid, addr, is_load}.
- **Tag update.** On each clock edge with `stall_all` = 0:
  - `mem_tag` <= `ex_tag`.
  - `ex_tag` <= {1, `id_write_addr`, `id_is_load`} if `id_valid` & `id_write_en` & `id_write_addr` != 0 & !`bubble_ex`; otherwise invalid.
  - With `stall_all` = 1, both tags hold.
- **Match.** Read port n matches a tag when `id_read_en_n` & tag.valid & `id_read_addr_n` == tag.addr. Address 0 never matches.
- **Forwarding.**
  - `fwd_sel_n` = 1 if port n matches `ex_tag` and `ex_tag` is not a load.
  - Else 2 if port n matches `mem_tag`.
  - Else 0.
  - WB needs no forwarding: the register file is write-before-read.
- **Load-use.** `load_use` = `id_valid` & (either port matches `ex_tag`) & `ex_tag.is_load`.
- **Priority, highest first:**
  - `mem_busy`: `stall_all` = 1, `stall_if` = 1, `bubble_ex` = 0, `flush_if` = 0.
  - `load_use`: `stall_if` = 1, `bubble_ex` = 1, `flush_if` = 0. A taken branch waits for its operand.
  - `branch_taken` & `id_valid`: `flush_if` = 1.
  - Otherwise all control outputs 0.
- **FSM states:**
  - RUN: entered from reset.
  - RUN -> MEM_WAIT when `mem_busy` = 1.
  - MEM_WAIT -> RUN when `mem_busy` = 0.
- **Watchdog.** An 8-bit `busy_cnt` clears in RUN and increments in MEM_WAIT while `mem_busy` = 1, saturating at `MEM_TIMEOUT`. When `busy_cnt` == `MEM_TIMEOUT` and `mem_busy` = 1, `mem_timeout` sets and stays set until reset.
- **Stall counter.** `stall_cnt` increments on every edge where `stall_if` = 1 and wraps from 0xFFFFFFFF to 0.

## Timing
- **Combinational outputs.** `fwd_sel_*`, `stall_if`, `bubble_ex`, `stall_all` and `flush_if` are combinational from the current tags and ID inputs; they are valid in the same cycle, with 0-cycle latency.
- **Registered state.** Tags, FSM state, `busy_cnt`, `mem_timeout` and `stall_cnt` are registered.
- **Load-use sequence.** A load-use costs exactly one bubble:
  - Cycle N: stall.
  - Cycle N+1: the load is in `mem_tag`, `fwd_sel` = 2 and the stall is released.
- **Reset values.** While `rst_n` = 0, which is asynchronous and effective immediately, including mid-stall:
  - Tags invalid, FSM in RUN, `busy_cnt` = 0, `mem_timeout` = 0, `stall_cnt` = 0.
  - All control outputs forced to 0; `fwd_sel_*` = 0.
- **Simultaneous `mem_busy` and `load_use`.** `stall_all` wins. `load_use` is re-evaluated after the release; tags are held, so it still fires.
- **Write to r0.** Never enters the scoreboard.
- **Branch while frozen.** `flush_if` is issued only in the cycle the branch is evaluated unstalled.

## Structure
- **Shared header.** Place these in a shared `hazard.v` header alongside `bus.v`:
  - Forwarding encodings `FWD_REG`, `FWD_EX`, `FWD_MEM`.
  - FSM encodings `HZ_RUN`, `HZ_MEM_WAIT`.
  - Tag width.
- **Sub-module.** Use one sub-module, `hazard_dep_match`, instantiated once per read port. It compares one read port against both tags and returns the EX match, MEM match and EX-is-load flags.

## Test plan
- **Forward from EX.** ADDIU writes r8, then ADDU reads r8 as rs -> `fwd_sel_1` = 1 in that cycle; no stall.
- **Load-use.** LW writes r9, next instruction BEQ reads r9 as rt:
  - Cycle N: `stall_if` = 1, `bubble_ex` = 1, `flush_if` = 0.
  - Cycle N+1: `fwd_sel_2` = 2 and `stall_if` = 0.
  - `stall_cnt` = 1.
- **r0 write.** LW with rt = 0, next instruction reads r0 -> no stall, `fwd_sel` = 0.
- **Memory freeze and watchdog.**
  - `mem_busy` high for 3 cycles -> `stall_all` = 1 for exactly those cycles, tags unchanged, `stall_cnt` = 3.
  - `mem_busy` held for 256 cycles with `MEM_TIMEOUT` = 255 -> `mem_timeout` = 1 and stays set after `mem_busy` falls.
- **Branch flush.** `branch_taken` with no hazard -> `flush_if` = 1 for one cycle. The same branch with a load-use on its operand -> `flush_if` = 0 during the stall and 1 in the following cycle.
- **Reset mid-operation.** Assert `rst_n` = 0 in MEM_WAIT with `stall_cnt` = 5 -> all outputs 0 immediately, with no clock edge; after release the FSM is in RUN with `stall_cnt` = 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding and FSM
// encodings, default widths and the scoreboard tag layout.
package pipe_hazard_ctrl_pkg;

    localparam int DEF_REG_ADDR_W  = 5;
    localparam int DEF_MEM_TIMEOUT = 255;
    localparam int BUSY_CNT_W      = 8;
    localparam int TAG_FLAG_W      = 2;  // valid + is_load around the address

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_e;

    // Tag packing is {valid, addr, is_load}.
    function automatic int tag_w(input int addr_w);
        return addr_w + TAG_FLAG_W;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// Compares one ID read port against the EX and MEM scoreboard tags.
module hazard_dep_match #(
    parameter int ADDR_W = 5
) (
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic              ex_load,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              ex_match,
    output logic              mem_match,
    output logic              ex_is_load
);

    logic port_live;

    // r0 is hardwired to zero, so a read of it never depends on anything.
    assign port_live  = read_en && (read_addr != '0);
    assign ex_match   = port_live && ex_valid  && (read_addr == ex_addr);
    assign mem_match  = port_live && mem_valid && (read_addr == mem_addr);
    assign ex_is_load = ex_match && ex_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: EX/MEM scoreboard, forwarding selects,
// load-use bubbles, branch flush, memory freeze with watchdog and stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_read_en_1,
    input  logic                  id_read_en_2,
    input  logic [REG_ADDR_W-1:0] id_read_addr_1,
    input  logic [REG_ADDR_W-1:0] id_read_addr_2,
    input  logic                  id_write_en,
    input  logic [REG_ADDR_W-1:0] id_write_addr,
    input  logic                  id_is_load,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    output logic                  stall_if,
    output logic                  bubble_ex,
    output logic                  stall_all,
    output logic                  flush_if,
    output logic [1:0]            fwd_sel_1,
    output logic [1:0]            fwd_sel_2,
    output logic                  mem_timeout,
    output logic [31:0]           stall_cnt
);

    localparam int TAG_W = tag_w(REG_ADDR_W);
    localparam logic [BUSY_CNT_W-1:0] BUSY_LIMIT = BUSY_CNT_W'(MEM_TIMEOUT);

    logic [TAG_W-1:0]      ex_tag_q, ex_tag_d, mem_tag_q, mem_tag_d;
    hz_state_e             state_q, state_d;
    logic [BUSY_CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic                  mem_timeout_q, mem_timeout_d;
    logic [31:0]           stall_cnt_q, stall_cnt_d;

    logic ex_m1, mem_m1, ex_ld1, ex_m2, mem_m2, ex_ld2, load_use;
    fwd_sel_e fwd_1, fwd_2;

    hazard_dep_match #(.ADDR_W(REG_ADDR_W)) u_match_1 (
        .read_en   (id_read_en_1),
        .read_addr (id_read_addr_1),
        .ex_valid  (ex_tag_q[TAG_W-1]),
        .ex_addr   (ex_tag_q[TAG_W-2:1]),
        .ex_load   (ex_tag_q[0]),
        .mem_valid (mem_tag_q[TAG_W-1]),
        .mem_addr  (mem_tag_q[TAG_W-2:1]),
        .ex_match  (ex_m1),
        .mem_match (mem_m1),
        .ex_is_load(ex_ld1)
    );

    hazard_dep_match #(.ADDR_W(REG_ADDR_W)) u_match_2 (
        .read_en   (id_read_en_2),
        .read_addr (id_read_addr_2),
        .ex_valid  (ex_tag_q[TAG_W-1]),
        .ex_addr   (ex_tag_q[TAG_W-2:1]),
        .ex_load   (ex_tag_q[0]),
        .mem_valid (mem_tag_q[TAG_W-1]),
        .mem_addr  (mem_tag_q[TAG_W-2:1]),
        .ex_match  (ex_m2),
        .mem_match (mem_m2),
        .ex_is_load(ex_ld2)
    );

    assign load_use = id_valid && (ex_ld1 || ex_ld2);

    // A load in EX has no result yet, so it falls through to the MEM tag check.
    assign fwd_1 = (ex_m1 && !ex_ld1) ? FWD_EX : (mem_m1 ? FWD_MEM : FWD_REG);
    assign fwd_2 = (ex_m2 && !ex_ld2) ? FWD_EX : (mem_m2 ? FWD_MEM : FWD_REG);
    assign fwd_sel_1 = fwd_1;
    assign fwd_sel_2 = fwd_2;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        stall_all = 1'b0;
        flush_if  = 1'b0;
        if (!rst_n) begin
            stall_if = 1'b0;
        end else if (mem_busy) begin
            stall_all = 1'b1;
            stall_if  = 1'b1;
        end else if (load_use) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
        end else if (branch_taken && id_valid) begin
            flush_if = 1'b1;
        end
    end

    always_comb begin
        ex_tag_d  = ex_tag_q;
        mem_tag_d = mem_tag_q;
        if (!stall_all) begin
            mem_tag_d = ex_tag_q;
            if (id_valid && id_write_en && (id_write_addr != '0) && !bubble_ex)
                ex_tag_d = {1'b1, id_write_addr, id_is_load};
            else
                ex_tag_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HZ_RUN:      if (mem_busy)  state_d = HZ_MEM_WAIT;
            HZ_MEM_WAIT: if (!mem_busy) state_d = HZ_RUN;
            default:     state_d = HZ_RUN;
        endcase
    end

    // busy_cnt holds the number of consecutive busy cycles seen so far.
    always_comb begin
        busy_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        if (state_d == HZ_MEM_WAIT && busy_cnt_q != BUSY_LIMIT)
            busy_cnt_d = busy_cnt_q + 1'b1;
        else if (state_d == HZ_MEM_WAIT)
            busy_cnt_d = busy_cnt_q;
        if (busy_cnt_q == BUSY_LIMIT && mem_busy)
            mem_timeout_d = 1'b1;
        stall_cnt_d = stall_if ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_tag_q      <= '0;
            mem_tag_q     <= '0;
            state_q       <= HZ_RUN;
            busy_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            ex_tag_q      <= ex_tag_d;
            mem_tag_q     <= mem_tag_d;
            state_q       <= state_d;
            busy_cnt_q    <= busy_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
